// File: rtl/fpu_lzd_pkg.sv
// Shared constants and elaboration-time helpers for the leading/trailing zero counter.
package fpu_lzd_pkg;

    localparam logic MODE_LZ = 1'b0;
    localparam logic MODE_TZ = 1'b1;

    function automatic int lzd_log2(input int w);
        int r;
        r = 0;
        while ((1 << r) < w) r++;
        return r;
    endfunction

    function automatic int lzd_cnt_w(input int w);
        return lzd_log2(w) + 1;
    endfunction

    function automatic int lzd_lat(input int w, input int reg_every);
        return (lzd_log2(w) + reg_every - 1) / reg_every;
    endfunction

    // Bit offsets of tree layer k inside the flattened val/pos buses.
    function automatic int lzd_voff(input int w, input int k);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) s += w >> j;
        return s;
    endfunction

    function automatic int lzd_poff(input int w, input int k);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) s += j * (w >> j);
        return s;
    endfunction

endpackage

// File: rtl/fpu_lzd_node.sv
// Purpose: one merge node of the zero-count tree (valid OR, position select).
// Latency: combinational.
// Backpressure: none; the enclosing pipeline owns all flow control.
module fpu_lzd_node #(
    parameter int LAYER = 1,
    localparam int PW = (LAYER > 1) ? LAYER - 1 : 1
) (
    input  logic             l_val,
    input  logic [PW-1:0]    l_pos,
    input  logic             r_val,
    input  logic [PW-1:0]    r_pos,
    output logic             o_val,
    output logic [LAYER-1:0] o_pos
);

    assign o_val = l_val | r_val;

    // First-layer children are single bits and carry no position.
    if (LAYER == 1) begin : g_pair
        logic unused_pos;
        assign unused_pos = ^{l_pos, r_pos};
        assign o_pos      = ~l_val;
    end else begin : g_merge
        assign o_pos = {~l_val, l_val ? l_pos : r_pos};
    end

endmodule

// File: rtl/fpu_lzd_pipe.sv
// Purpose: pipelined leading/trailing zero counter built from a binary merge tree.
// Latency: LAT = ceil(log2(WIDTH)/REG_EVERY) cycles from acceptance to out_valid.
// Backpressure: per-stage valid/ready with bubble collapse; flush and reset drop in-flight work.
module fpu_lzd_pipe
    import fpu_lzd_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2,
    localparam int LOG2W    = lzd_log2(WIDTH),
    localparam int CNT_W    = lzd_cnt_w(WIDTH),
    localparam int LAT      = lzd_lat(WIDTH, REG_EVERY)
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero
);

    localparam int VT = lzd_voff(WIDTH, LOG2W + 1);
    localparam int PT = lzd_poff(WIDTH, LOG2W + 1);
    localparam int VF = lzd_voff(WIDTH, LOG2W);
    localparam int PF = lzd_poff(WIDTH, LOG2W);

    logic [WIDTH-1:0] leaf;
    logic [VT-1:0]    v_c, v_q;
    logic [PT-1:0]    p_c, p_q;
    logic [LAT-1:0]   vld, vin, adv;
    logic             accept;

    // Trailing-zero mode mirrors the operand so the same MSB-first tree applies.
    always_comb begin
        leaf = in_data;
        if (in_mode == MODE_TZ) begin
            for (int i = 0; i < WIDTH; i++) leaf[i] = in_data[WIDTH-1-i];
        end
    end

    assign v_c[WIDTH-1:0] = leaf;
    assign v_q[WIDTH-1:0] = v_c[WIDTH-1:0];

    genvar k, n;
    for (k = 1; k <= LOG2W; k++) begin : g_layer
        localparam int NN = WIDTH >> k;
        localparam int VO = lzd_voff(WIDTH, k);
        localparam int VI = lzd_voff(WIDTH, k - 1);
        localparam int PO = lzd_poff(WIDTH, k);
        localparam int PI = lzd_poff(WIDTH, k - 1);

        for (n = 0; n < NN; n++) begin : g_node
            logic [(k > 1 ? k - 1 : 1)-1:0] lp, rp;
            if (k == 1) begin : g_lp_leaf
                assign lp = 1'b0;
                assign rp = 1'b0;
            end else begin : g_lp_tree
                assign lp = p_q[PI + (2*n+1)*(k-1) +: k-1];
                assign rp = p_q[PI + (2*n)*(k-1)   +: k-1];
            end
            fpu_lzd_node #(.LAYER(k)) u_node (
                .l_val (v_q[VI + 2*n + 1]),
                .l_pos (lp),
                .r_val (v_q[VI + 2*n]),
                .r_pos (rp),
                .o_val (v_c[VO + n]),
                .o_pos (p_c[PO + n*k +: k])
            );
        end

        // The last layer is always registered, but into out_count/out_zero below.
        if (k < LOG2W && (k % REG_EVERY) == 0) begin : g_reg
            localparam int S = k / REG_EVERY - 1;
            logic [NN-1:0]   vr;
            logic [NN*k-1:0] pr;
            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l) begin
                    vr <= '0;
                    pr <= '0;
                end else if (adv[S]) begin
                    vr <= v_c[VO +: NN];
                    pr <= p_c[PO +: NN*k];
                end
            end
            assign v_q[VO +: NN]   = vr;
            assign p_q[PO +: NN*k] = pr;
        end else begin : g_thru
            assign v_q[VO +: NN]   = v_c[VO +: NN];
            assign p_q[PO +: NN*k] = p_c[PO +: NN*k];
        end
    end

    // A stage moves when it is empty or its successor moves.
    always_comb begin
        logic go;
        go           = ~vld[LAT-1] | out_ready;
        adv[LAT-1]   = go;
        for (int s = LAT - 2; s >= 0; s--) begin
            go     = ~vld[s] | go;
            adv[s] = go;
        end
    end

    assign in_ready = rst_l & ~flush & adv[0];
    assign accept   = in_valid & in_ready;

    always_comb begin
        vin    = '0;
        vin[0] = accept;
        for (int s = 1; s < LAT; s++) vin[s] = vld[s-1];
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            vld <= '0;
        end else if (flush) begin
            vld <= '0;
        end else begin
            for (int s = 0; s < LAT; s++) begin
                if (adv[s]) vld[s] <= vin[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            out_count <= '0;
            out_zero  <= 1'b0;
        end else if (adv[LAT-1]) begin
            out_zero  <= ~v_q[VF];
            out_count <= v_q[VF] ? {1'b0, p_q[PF +: LOG2W]} : CNT_W'(WIDTH);
        end
    end

    assign out_valid = vld[LAT-1];

endmodule

// File: tb/tb_fpu_lzd_pipe.sv
// Purpose: directed bench for fpu_lzd_pipe (WIDTH=32, REG_EVERY=2) with a result scoreboard.
// Latency: checks the 3-cycle accept-to-result path and back-to-back issue.
// Backpressure: covers stall, flush and mid-flight reset.
module tb_fpu_lzd_pipe;

    logic        clk = 1'b0;
    logic        rst_l = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_mode = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [5:0]  out_count;
    logic        out_zero;

    int          checks = 0;
    int          failures = 0;
    logic [6:0]  exp_q[$];
    logic [6:0]  mon_e;

    always #5 clk = ~clk;

    fpu_lzd_pipe #(.WIDTH(32), .REG_EVERY(2)) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_zero  (out_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference count: scan from the MSB of the (optionally mirrored) operand.
    function automatic logic [6:0] model(input logic [31:0] d, input logic m);
        logic [31:0] x;
        x = d;
        if (m) begin
            for (int i = 0; i < 32; i++) x[i] = d[31-i];
        end
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) return {1'b0, 6'(31 - i)};
        end
        return {1'b1, 6'd32};
    endfunction

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            chk("result_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("out_count", 32'(out_count), 32'(mon_e[5:0]));
                chk("out_zero", 32'(out_zero), 32'(mon_e[6]));
            end
        end
        if (in_valid && in_ready) exp_q.push_back(model(in_data, in_mode));
    end

    task automatic send(input logic [31:0] d, input logic m);
        int n;
        n = 0;
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        #1 rst_l = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_l = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        send(32'h0001_0000, 1'b0);
        wait_out(n);
        chk("latency_3", 32'(n), 32'd3);
        drain();

        send(32'h0000_0000, 1'b0);
        send(32'h0000_0000, 1'b1);
        drain();

        send(32'h8000_0000, 1'b0);
        send(32'h8000_0000, 1'b1);
        wait_out(n);
        chk("b2b_first", 32'(n), 32'd2);
        @(negedge clk);
        chk("b2b_second", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("b2b_after", 32'(out_valid), 32'd0);
        drain();

        out_ready = 1'b0;
        send(32'h1, 1'b0);
        send(32'h2, 1'b0);
        send(32'h4, 1'b0);
        in_data  = 32'h8;
        in_mode  = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_count", 32'(out_count), 32'd31);
        @(negedge clk);
        chk("stall_hold_count", 32'(out_count), 32'd31);
        chk("stall_hold_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        send(32'h10, 1'b0);
        send(32'h20, 1'b0);
        in_data  = 32'h40;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (6) begin
            @(negedge clk);
            chk("flush_no_out", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(32'h100, 1'b1);
        wait_out(n);
        chk("post_flush_latency", 32'(n), 32'd3);
        drain();

        send(32'h100, 1'b0);
        send(32'h200, 1'b0);
        send(32'h400, 1'b0);
        rst_l = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_count", 32'(out_count), 32'd0);
        chk("arst_out_zero", 32'(out_zero), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_l = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("arst_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(32'hFFFF_FFFF, 1'b1);
        wait_out(n);
        chk("final_latency", 32'(n), 32'd3);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
